// File: rtl/eth_rx_parse.sv
// Ethernet/IPv4/UDP receive filter: matches the header in place and streams the UDP payload.
// Optional FCS checking is compiled in with the ETH_RX_CRC_CHECK_EN macro.
module eth_rx_parse #(
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned VLAN_TAG     = 1,
  parameter logic [47:0] MAC_DST_ADDR = 48'h000000FCD4F2,
  parameter logic [31:0] IP_DST_ADDR  = {8'd206, 8'd200, 8'd127, 8'd128},
  parameter logic [15:0] DST_PORT     = 16'd18170,
  parameter int unsigned PKT_LEN_W    = 16,
  localparam int unsigned KEEP_W      = DATA_W / 8,
  localparam int unsigned LEN_W       = $clog2(KEEP_W + 1)
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic                 phy_valid_i,
  input  logic                 phy_start_i,
  input  logic                 phy_term_i,
  input  logic [LEN_W-1:0]     phy_term_len_i,
  input  logic [DATA_W-1:0]    phy_data_i,
  output logic                 app_valid_o,
  output logic [DATA_W-1:0]    app_data_o,
  output logic [LEN_W-1:0]     app_len_o,
  output logic                 app_start_o,
  output logic                 app_last_o,
  output logic [PKT_LEN_W-1:0] app_pkt_len_o,
  output logic                 app_cancel_o,
  output logic                 app_crc_v_o,
  output logic                 app_crc_err_o
);

  localparam int unsigned MAC_HEAD_N   = 8 + 12 + 4 * VLAN_TAG + 2;
  localparam int unsigned HEAD_N       = MAC_HEAD_N + 20 + 8;
  localparam int unsigned CNT_W        = $clog2(HEAD_N + 1);
  localparam int unsigned IP_DST_POS   = MAC_HEAD_N + 16;
  localparam int unsigned UDP_PORT_POS = MAC_HEAD_N + 22;
  localparam int unsigned UDP_LEN_POS  = MAC_HEAD_N + 24;

  if ((HEAD_N % KEEP_W) != 0) begin : g_head_align
    $error("eth_rx_parse: header length must be a multiple of the beat width");
  end

  typedef enum logic [2:0] {IDLE, HEAD, DATA, FOOT, DROP} state_t;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [PKT_LEN_W-1:0] rem, rem_nxt, pkt_len_nxt;
  logic [15:0]          udp_len, udp_len_nxt, udp_len_cap;
  logic                 first, first_nxt;
  logic                 hdr_bad, hdr_end, crc_bad;
  logic                 valid_nxt, start_nxt, last_nxt, cancel_nxt, crc_v_nxt, crc_err_nxt;
  logic [DATA_W-1:0]    data_nxt;
  logic [LEN_W-1:0]     len_nxt;

  // Expected header byte at a frame position; bit 8 flags a checked position.
  function automatic logic [8:0] hdr_ref(input int unsigned pos);
    logic [8:0] r;
    r = '0;
    if (pos >= 32'd8 && pos <= 32'd13)
      r = {1'b1, 8'(MAC_DST_ADDR >> (8 * (13 - pos)))};
    else if (VLAN_TAG != 0 && pos == 32'd20) r = 9'h181;
    else if (VLAN_TAG != 0 && pos == 32'd21) r = 9'h100;
    else if (pos == MAC_HEAD_N - 2)          r = 9'h108;
    else if (pos == MAC_HEAD_N - 1)          r = 9'h100;
    else if (pos == MAC_HEAD_N)              r = 9'h145;
    else if (pos == MAC_HEAD_N + 9)          r = 9'h111;
    else if (pos >= IP_DST_POS && pos <= IP_DST_POS + 3)
      r = {1'b1, 8'(IP_DST_ADDR >> (8 * (IP_DST_POS + 3 - pos)))};
    else if (pos == UDP_PORT_POS)            r = {1'b1, DST_PORT[15:8]};
    else if (pos == UDP_PORT_POS + 1)        r = {1'b1, DST_PORT[7:0]};
    return r;
  endfunction

  always_comb begin : hdr_check
    int unsigned pos;
    logic [8:0]  ref_b;
    logic [7:0]  lane;
    hdr_bad     = 1'b0;
    udp_len_cap = udp_len;
    for (int unsigned i = 0; i < KEEP_W; i++) begin
      pos   = 32'(cnt) + i;
      lane  = phy_data_i[8*i +: 8];
      ref_b = hdr_ref(pos);
      if (ref_b[8] && lane != ref_b[7:0]) hdr_bad = 1'b1;
      if (pos == UDP_LEN_POS)     udp_len_cap[15:8] = lane;
      if (pos == UDP_LEN_POS + 1) udp_len_cap[7:0]  = lane;
    end
  end

  assign hdr_end = (32'(cnt) + KEEP_W == HEAD_N);

`ifdef ETH_RX_CRC_CHECK_EN
  logic [31:0] crc, crc_beat, crc_nxt;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int k = 0; k < 8; k++) r = (r >> 1) ^ ((r[0] ^ d[k]) ? 32'hEDB88320 : 32'h0);
    return r;
  endfunction

  function automatic logic [31:0] bitrev32(input logic [31:0] c);
    logic [31:0] r;
    for (int k = 0; k < 32; k++) r[k] = c[31-k];
    return r;
  endfunction

  // Reflected CRC over everything after the preamble; term beats only count their valid lanes.
  always_comb begin : crc_calc
    crc_beat = crc;
    for (int unsigned i = 0; i < KEEP_W; i++) begin
      if ((state != HEAD || 32'(cnt) + i >= 32'd8) && (!phy_term_i || i < 32'(phy_term_len_i)))
        crc_beat = crc_byte(crc_beat, phy_data_i[8*i +: 8]);
    end
    crc_nxt = crc;
    if (phy_valid_i) begin
      if (phy_start_i)                          crc_nxt = '1;
      else if (state inside {HEAD, DATA, FOOT}) crc_nxt = crc_beat;
    end
  end

  assign crc_bad = (bitrev32(crc_beat) != 32'hC704DD7B);

  always_ff @(posedge clk or negedge nreset) begin : crc_reg
    if (!nreset) crc <= '1;
    else         crc <= crc_nxt;
  end
`else
  logic term_len_unused;
  assign term_len_unused = ^phy_term_len_i;
  assign crc_bad         = 1'b0;
`endif

  always_comb begin : fsm_next
    state_nxt   = state;
    cnt_nxt     = cnt;
    rem_nxt     = rem;
    udp_len_nxt = udp_len;
    first_nxt   = first;
    pkt_len_nxt = app_pkt_len_o;
    valid_nxt   = 1'b0;
    start_nxt   = 1'b0;
    last_nxt    = 1'b0;
    cancel_nxt  = 1'b0;
    crc_v_nxt   = 1'b0;
    crc_err_nxt = 1'b0;
    data_nxt    = '0;
    len_nxt     = '0;
    if (phy_valid_i) begin
      if (phy_start_i) begin
        // A new frame always wins; only an in-flight payload needs cancelling.
        cancel_nxt = (state == HEAD) || (state == DATA);
        state_nxt  = HEAD;
        cnt_nxt    = CNT_W'(KEEP_W);
      end else begin
        case (state)
          HEAD: begin
            if (phy_term_i) begin
              cancel_nxt = 1'b1;
              state_nxt  = IDLE;
            end else if (hdr_bad) begin
              cancel_nxt = 1'b1;
              state_nxt  = DROP;
            end else begin
              udp_len_nxt = udp_len_cap;
              cnt_nxt     = cnt + CNT_W'(KEEP_W);
              if (hdr_end) begin
                if (udp_len_cap < 16'd9) begin
                  cancel_nxt = 1'b1;
                  state_nxt  = DROP;
                end else begin
                  rem_nxt     = PKT_LEN_W'(udp_len_cap - 16'd8);
                  pkt_len_nxt = PKT_LEN_W'(udp_len_cap - 16'd8);
                  first_nxt   = 1'b1;
                  state_nxt   = DATA;
                end
              end
            end
          end
          DATA: begin
            if (phy_term_i) begin
              cancel_nxt = 1'b1;
              state_nxt  = IDLE;
            end else begin
              len_nxt   = (rem >= PKT_LEN_W'(KEEP_W)) ? LEN_W'(KEEP_W) : LEN_W'(rem);
              last_nxt  = (rem <= PKT_LEN_W'(KEEP_W));
              valid_nxt = 1'b1;
              start_nxt = first;
              first_nxt = 1'b0;
              rem_nxt   = rem - PKT_LEN_W'(len_nxt);
              for (int unsigned i = 0; i < KEEP_W; i++)
                if (i < 32'(len_nxt)) data_nxt[8*i +: 8] = phy_data_i[8*i +: 8];
              if (last_nxt) state_nxt = FOOT;
            end
          end
          FOOT: begin
            if (phy_term_i) begin
              crc_v_nxt   = 1'b1;
              crc_err_nxt = crc_bad;
              state_nxt   = IDLE;
            end
          end
          DROP: if (phy_term_i) state_nxt = IDLE;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin : fsm_reg
    if (!nreset) begin
      state         <= IDLE;
      cnt           <= '0;
      rem           <= '0;
      udp_len       <= '0;
      first         <= 1'b0;
      app_valid_o   <= 1'b0;
      app_data_o    <= '0;
      app_len_o     <= '0;
      app_start_o   <= 1'b0;
      app_last_o    <= 1'b0;
      app_pkt_len_o <= '0;
      app_cancel_o  <= 1'b0;
      app_crc_v_o   <= 1'b0;
      app_crc_err_o <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      rem           <= rem_nxt;
      udp_len       <= udp_len_nxt;
      first         <= first_nxt;
      app_valid_o   <= valid_nxt;
      app_data_o    <= data_nxt;
      app_len_o     <= len_nxt;
      app_start_o   <= start_nxt;
      app_last_o    <= last_nxt;
      app_pkt_len_o <= pkt_len_nxt;
      app_cancel_o  <= cancel_nxt;
      app_crc_v_o   <= crc_v_nxt;
      app_crc_err_o <= crc_err_nxt;
    end
  end

endmodule

// File: tb/tb_eth_rx_parse.sv
// Directed bench for eth_rx_parse: builds frames byte by byte and checks the app stream.
module tb_eth_rx_parse;

  logic        clk = 1'b0;
  logic        nreset;
  logic        phy_valid_i, phy_start_i, phy_term_i;
  logic [1:0]  phy_term_len_i;
  logic [15:0] phy_data_i;
  logic        app_valid_o;
  logic [15:0] app_data_o;
  logic [1:0]  app_len_o;
  logic        app_start_o, app_last_o;
  logic [15:0] app_pkt_len_o;
  logic        app_cancel_o, app_crc_v_o, app_crc_err_o;

  localparam logic [47:0] MAC_OK  = 48'h000000FCD4F2;
  localparam logic [47:0] MAC_BAD = 48'h112233445566;
`ifdef ETH_RX_CRC_CHECK_EN
  localparam logic EXP_BAD_ERR = 1'b1;
`else
  localparam logic EXP_BAD_ERR = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0]  frm[$];
  logic [15:0] od[$];
  logic [1:0]  ol[$];
  logic        os[$];
  logic        oe[$];
  int          cancel_cnt, cancel_beat, crcv_cnt;
  logic        crc_err_seen;

  eth_rx_parse dut (
    .clk(clk), .nreset(nreset),
    .phy_valid_i(phy_valid_i), .phy_start_i(phy_start_i), .phy_term_i(phy_term_i),
    .phy_term_len_i(phy_term_len_i), .phy_data_i(phy_data_i),
    .app_valid_o(app_valid_o), .app_data_o(app_data_o), .app_len_o(app_len_o),
    .app_start_o(app_start_o), .app_last_o(app_last_o), .app_pkt_len_o(app_pkt_len_o),
    .app_cancel_o(app_cancel_o), .app_crc_v_o(app_crc_v_o), .app_crc_err_o(app_crc_err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int k = 0; k < 8; k++) r = (r >> 1) ^ ((r[0] ^ d[k]) ? 32'hEDB88320 : 32'h0);
    return r;
  endfunction

  task automatic push16(input logic [15:0] w);
    frm.push_back(w[15:8]);
    frm.push_back(w[7:0]);
  endtask

  task automatic push32(input logic [31:0] w);
    push16(w[31:16]);
    push16(w[15:0]);
  endtask

  // Preamble, VLAN-tagged MAC, IPv4, UDP, payload A1,B2,C3..., pad 5A to even, FCS.
  task automatic build(input logic [47:0] dst, input logic [15:0] ulen, input bit bad_fcs);
    logic [31:0] c;
    frm.delete();
    repeat (7) frm.push_back(8'h55);
    frm.push_back(8'hD5);
    push16(dst[47:32]); push16(dst[31:16]); push16(dst[15:0]);
    push16(16'h0200); push32(32'h00000001);
    push16(16'h8100); push16(16'h0005); push16(16'h0800);
    push16(16'h4500); push16(16'd20 + ulen); push16(16'h0000); push16(16'h4000);
    push16(16'h4011); push16(16'h0000); push32(32'h0A000001); push32(32'hCEC87F80);
    push16(16'h1234); push16(16'd18170); push16(ulen); push16(16'h0000);
    for (int i = 0; i < int'(ulen) - 8; i++) frm.push_back(8'(8'hA1 + 8'h11 * i));
    if (frm.size() % 2 != 0) frm.push_back(8'h5A);
    c = 32'hFFFFFFFF;
    for (int i = 8; i < frm.size(); i++) c = crc_upd(c, frm[i]);
    c = ~c;
    for (int i = 0; i < 4; i++) frm.push_back(c[8*i +: 8]);
    if (bad_fcs) frm[frm.size()-1] = frm[frm.size()-1] ^ 8'h01;
  endtask

  task automatic drive(input logic v, input logic s, input logic t, input logic [1:0] tl,
                       input logic [15:0] d, input int idx);
    phy_valid_i = v; phy_start_i = s; phy_term_i = t; phy_term_len_i = tl; phy_data_i = d;
    @(posedge clk);
    #1;
    if (app_valid_o) begin
      od.push_back(app_data_o); ol.push_back(app_len_o);
      os.push_back(app_start_o); oe.push_back(app_last_o);
    end
    if (app_cancel_o) begin cancel_cnt++; cancel_beat = idx; end
    if (app_crc_v_o) begin crcv_cnt++; crc_err_seen = app_crc_err_o; end
  endtask

  task automatic send(input int lim, input bit term_last, input int stall_at, input int stall_n);
    int nb, last;
    logic [7:0] lo, hi;
    od.delete(); ol.delete(); os.delete(); oe.delete();
    cancel_cnt = 0; cancel_beat = -1; crcv_cnt = 0; crc_err_seen = 1'b0;
    nb   = (frm.size() + 1) / 2;
    last = (lim < nb) ? lim - 1 : nb - 1;
    for (int b = 0; b <= last; b++) begin
      if (b == stall_at) repeat (stall_n) drive(1'b0, 1'b0, 1'b0, 2'd0, 16'h0, -1);
      lo = frm[2*b];
      hi = (2*b + 1 < frm.size()) ? frm[2*b + 1] : 8'h00;
      drive(1'b1, b == 0, term_last && b == last, (2*b + 1 < frm.size()) ? 2'd2 : 2'd1, {hi, lo}, b);
    end
    drive(1'b0, 1'b0, 1'b0, 2'd0, 16'h0, -1);
    drive(1'b0, 1'b0, 1'b0, 2'd0, 16'h0, -1);
  endtask

  initial begin
    nreset = 1'b0;
    phy_valid_i = 1'b0; phy_start_i = 1'b0; phy_term_i = 1'b0;
    phy_term_len_i = 2'd0; phy_data_i = 16'h0;
    repeat (3) @(negedge clk);
    check("rst_valid",   32'(app_valid_o),   32'd0);
    check("rst_pkt_len", 32'(app_pkt_len_o), 32'd0);
    check("rst_cancel",  32'(app_cancel_o),  32'd0);
    check("rst_crc_v",   32'(app_crc_v_o),   32'd0);
    nreset = 1'b1;
    @(negedge clk);

    // Good frame, 4 payload bytes
    build(MAC_OK, 16'd12, 1'b0);
    send(1000, 1'b1, -1, 0);
    check("g4_beats",  32'(od.size()), 32'd2);
    check("g4_d0",     32'(od[0]), 32'hB2A1);
    check("g4_d1",     32'(od[1]), 32'hD4C3);
    check("g4_len0",   32'(ol[0]), 32'd2);
    check("g4_len1",   32'(ol[1]), 32'd2);
    check("g4_start",  32'({os[0], os[1]}), 32'b10);
    check("g4_last",   32'({oe[0], oe[1]}), 32'b01);
    check("g4_pktlen", 32'(app_pkt_len_o), 32'd4);
    check("g4_crcv",   32'(crcv_cnt), 32'd1);
    check("g4_crcerr", 32'(crc_err_seen), 32'd0);
    check("g4_cancel", 32'(cancel_cnt), 32'd0);

    // Odd payload: pad byte 5A must be masked off
    build(MAC_OK, 16'd11, 1'b0);
    send(1000, 1'b1, -1, 0);
    check("g3_beats",  32'(od.size()), 32'd2);
    check("g3_d1",     32'(od[1]), 32'h00C3);
    check("g3_len",    32'({ol[0], ol[1]}), 32'b1001);
    check("g3_last",   32'({oe[0], oe[1]}), 32'b01);
    check("g3_pktlen", 32'(app_pkt_len_o), 32'd3);
    check("g3_crcv",   32'(crcv_cnt), 32'd1);

    // Wrong destination MAC: mismatch in beat 4 (bytes 8,9)
    build(MAC_BAD, 16'd12, 1'b0);
    send(1000, 1'b1, -1, 0);
    check("mac_cancel_n",    32'(cancel_cnt), 32'd1);
    check("mac_cancel_beat", 32'(cancel_beat), 32'd4);
    check("mac_beats",       32'(od.size()), 32'd0);
    check("mac_crcv",        32'(crcv_cnt), 32'd0);

    // Corrupted FCS
    build(MAC_OK, 16'd12, 1'b1);
    send(1000, 1'b1, -1, 0);
    check("fcs_beats",  32'(od.size()), 32'd2);
    check("fcs_crcv",   32'(crcv_cnt), 32'd1);
    check("fcs_crcerr", 32'(crc_err_seen), 32'(EXP_BAD_ERR));

    // Three idle cycles after the first payload beat
    build(MAC_OK, 16'd14, 1'b0);
    send(1000, 1'b1, 28, 3);
    check("stall_beats",  32'(od.size()), 32'd3);
    check("stall_d0",     32'(od[0]), 32'hB2A1);
    check("stall_d1",     32'(od[1]), 32'hD4C3);
    check("stall_d2",     32'(od[2]), 32'hF6E5);
    check("stall_last",   32'({oe[0], oe[1], oe[2]}), 32'b001);
    check("stall_pktlen", 32'(app_pkt_len_o), 32'd6);
    check("stall_cancel", 32'(cancel_cnt), 32'd0);

    // UDP length 8 means no payload: dropped
    build(MAC_OK, 16'd8, 1'b0);
    send(1000, 1'b1, -1, 0);
    check("ulen8_cancel", 32'(cancel_cnt), 32'd1);
    check("ulen8_beats",  32'(od.size()), 32'd0);
    check("ulen8_crcv",   32'(crcv_cnt), 32'd0);

    // Term on the first payload beat aborts
    build(MAC_OK, 16'd14, 1'b0);
    send(28, 1'b1, -1, 0);
    check("tdata_cancel", 32'(cancel_cnt), 32'd1);
    check("tdata_beat",   32'(cancel_beat), 32'd27);
    check("tdata_beats",  32'(od.size()), 32'd0);

    // New start in the middle of a payload
    build(MAC_OK, 16'd14, 1'b0);
    send(28, 1'b0, -1, 0);
    check("cut_beats", 32'(od.size()), 32'd1);
    build(MAC_OK, 16'd12, 1'b0);
    send(1000, 1'b1, -1, 0);
    check("restart_cancel", 32'(cancel_cnt), 32'd1);
    check("restart_beat",   32'(cancel_beat), 32'd0);
    check("restart_beats",  32'(od.size()), 32'd2);
    check("restart_d0",     32'(od[0]), 32'hB2A1);
    check("restart_start",  32'(os[0]), 32'd1);
    check("restart_pktlen", 32'(app_pkt_len_o), 32'd4);
    check("restart_crcv",   32'(crcv_cnt), 32'd1);

    // Asynchronous reset inside the header
    build(MAC_OK, 16'd12, 1'b0);
    send(10, 1'b0, -1, 0);
    check("pre_rst_pktlen", 32'(app_pkt_len_o), 32'd4);
    #2 nreset = 1'b0;
    #1;
    check("arst_pktlen", 32'(app_pkt_len_o), 32'd0);
    check("arst_valid",  32'(app_valid_o), 32'd0);
    check("arst_cancel", 32'(app_cancel_o), 32'd0);
    @(negedge clk);
    nreset = 1'b1;
    cancel_cnt = 0;
    drive(1'b1, 1'b0, 1'b0, 2'd0, 16'h4500, -1);
    check("post_rst_cancel", 32'(cancel_cnt), 32'd0);
    check("post_rst_valid",  32'(app_valid_o), 32'd0);
    build(MAC_OK, 16'd12, 1'b0);
    send(1000, 1'b1, -1, 0);
    check("post_rst_beats", 32'(od.size()), 32'd2);
    check("post_rst_d1",    32'(od[1]), 32'hD4C3);
    check("post_rst_crcv",  32'(crcv_cnt), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/eth_rx_parse.md
ETH_RX_PARSE -- requirements
Module: eth_rx_parse

Interface
REQ-001 DATA_W, 16, PHY/app datapath width in bits; KEEP_W = DATA_W/8.
REQ-002 VLAN_TAG, 1, 802.1Q tag present in the MAC header; MAC_HEAD_N = 8 + 12 + 4*VLAN_TAG + 2.
REQ-003 MAC_DST_ADDR, 48'h000000FCD4F2, accepted destination MAC.
REQ-004 IP_DST_ADDR, {206,200,127,128}, accepted IPv4 destination.
REQ-005 DST_PORT, 16'd18170, accepted UDP destination port.
REQ-006 PKT_LEN_W, 16, UDP length width.
REQ-007 clk  in  1  clock; reset is asynchronous and active-low.
REQ-008 nreset  in  1  asynchronous active-low reset.
REQ-009 phy_valid_i  in  1  beat present; low = PHY idle/stall.
REQ-010 phy_start_i  in  1  first beat of frame (preamble byte 0 in lane 0).
REQ-011 phy_term_i  in  1  terminate beat.
REQ-012 phy_term_len_i  in  $clog2(KEEP_W+1)  valid bytes in the term beat (0..KEEP_W).
REQ-013 phy_data_i  in  DATA_W  frame bytes, lane 0 first on the wire.
REQ-014 app_valid_o  out  1  payload beat valid.
REQ-015 app_data_o  out  DATA_W  UDP payload bytes.
REQ-016 app_len_o  out  $clog2(KEEP_W+1)  valid bytes in app_data_o, lane 0 upward.
REQ-017 app_start_o, app_last_o  out  1 each  first/last payload beat.
REQ-018 app_pkt_len_o  out  PKT_LEN_W  UDP length minus 8; stable from app_start_o until the next frame.
REQ-019 app_cancel_o  out  1  one-cycle pulse: frame dropped or aborted.
REQ-020 app_crc_v_o, app_crc_err_o  out  1 each  FCS verdict strobe and error flag.

Function
REQ-021 HEAD_N = MAC_HEAD_N + 20 + 8 (54 by default); HEAD_N % KEEP_W != 0 SHALL be an elaboration error.
REQ-022 FSM states IDLE, HEAD, DATA, FOOT, DROP; a beat advances the state only when phy_valid_i=1.
REQ-023 IDLE->HEAD on phy_start_i; a byte counter starts at 0 and increments by KEEP_W per beat.
REQ-024 In HEAD, each byte is compared in place: MAC dst, ethertype 0x8100 (if VLAN_TAG) and 0x0800, IPv4 version/IHL 0x45, protocol 17, IP dst, UDP dst port; UDP length is captured.
REQ-025 Any mismatch, or UDP length < 9, SHALL pulse app_cancel_o and enter DROP.
REQ-026 HEAD->DATA after byte HEAD_N-1; payload remaining = UDP length - 8, PKT_LEN_W wide, no wrap.
REQ-027 DATA: per beat, app_len_o = min(remaining, KEEP_W); app_last_o when remaining <= KEEP_W, then DATA->FOOT.
REQ-028 App outputs are registered: 1-cycle latency from the input beat.
REQ-029 FOOT consumes padding and FCS until phy_term_i, then goes to IDLE.
REQ-030 phy_term_i in HEAD or DATA SHALL pulse app_cancel_o and go to IDLE; app_last_o is not asserted.
REQ-031 phy_start_i in any non-IDLE state SHALL pulse app_cancel_o (only if in HEAD/DATA) and restart HEAD at byte 0 in the same cycle.
REQ-032 DROP ignores beats until phy_term_i, then goes to IDLE; no app_valid_o.
REQ-033 Term in the same beat as the last header byte is an abort (REQ-030).

Reset
REQ-034 nreset low asynchronously forces IDLE; all app_* outputs 0, app_pkt_len_o 0.
REQ-035 Reset mid-frame discards the frame without an app_cancel_o pulse; the first beat after release is ignored unless it carries phy_start_i.

Configuration
REQ-036 ETH_RX_CRC_CHECK_EN defined: CRC-32 is updated byte-serially over all bytes after the 8 preamble bytes through the term bytes; at term in FOOT, app_crc_v_o pulses one cycle with app_crc_err_o = (residue != 32'hC704DD7B).
REQ-037 ETH_RX_CRC_CHECK_EN undefined: no CRC logic; app_crc_v_o pulses at term in FOOT with app_crc_err_o tied 0.

Verification
REQ-038 Matching frame, UDP length 12 (4 bytes payload), good FCS -> 2 app beats, len 2,2, start on the first, last on the second; app_pkt_len_o=4; crc_v=1, err=0.
REQ-039 UDP length 11 -> beats len 2,1, last on the second; padding bytes not output.
REQ-040 MAC dst 0x112233445566 -> app_cancel_o pulse at that beat+1; no app_valid_o; IDLE after term.
REQ-041 Corrupt one FCS bit with CRC_EN -> app_crc_err_o=1 at term+1; without the macro -> 0.
REQ-042 phy_valid_i low for 3 cycles mid-payload -> output stalls, byte order preserved, counters unchanged.
REQ-043 phy_start_i mid-DATA -> app_cancel_o pulse, new frame parsed correctly; async reset mid-HEAD -> outputs 0 immediately.
